// File: rtl/cfgtag_link_arb_pkg.sv
// Shared types and sizing helpers for the cfgtag link arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cfgtag_link_arb_pkg;

    // First error cause seen; only built into the arbiter when
    // CFGTAG_LINK_ARB_ERR_EN is defined.
    typedef enum logic [1:0] {
        NONE       = 2'd0,
        FIFO_OVF   = 2'd1,
        CREDIT_OVF = 2'd2
    } err_cause_e;

    // Width needed to hold a credit count of 0..max_credits inclusive.
    function automatic int credit_cnt_w(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/cfgtag_link_arbiter_if.sv
// Gateway-side and network-side signals of the cfgtag link arbiter.
// Latency: n/a (wires only).
// Backpressure: credit based in both directions (credit_o upstream, credit_i downstream).
//
// Ports: valid_i/data_i (per gateway words), credit_o (per gateway credit return),
//        credit_i (downstream credit), valid_o/data_o/grant_id_o (registered output word).
interface cfgtag_link_arbiter_if #(
    parameter int num_in_p     = 4,
    parameter int data_width_p = 32
);
    logic [num_in_p-1:0]                   valid_i;
    logic [num_in_p-1:0][data_width_p-1:0] data_i;
    logic [num_in_p-1:0]                   credit_o;
    logic                                  credit_i;
    logic                                  valid_o;
    logic [data_width_p-1:0]               data_o;
    logic [$clog2(num_in_p)-1:0]           grant_id_o;

    // Driven by the gateways / network side.
    modport master (
        output valid_i, data_i, credit_i,
        input  credit_o, valid_o, data_o, grant_id_o
    );

    // The arbiter itself.
    modport slave (
        input  valid_i, data_i, credit_i,
        output credit_o, valid_o, data_o, grant_id_o
    );
endinterface

// File: rtl/cfgtag_link_arb_fifo.sv
// Small per-input ring FIFO; read data is combinational from the head slot.
// Latency: write at edge t is visible (not empty) in cycle t+1.
// Backpressure: none; a write while full is only taken if a read happens in the same cycle.
//
// Ports: clk, reset (async active-low), i_wr/i_wr_dat, i_rd, o_rd_dat, o_empty, o_full.
module cfgtag_link_arb_fifo #(
    parameter int depth_p = 2,
    parameter int width_p = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr,
    input  logic [width_p-1:0] i_wr_dat,
    input  logic               i_rd,
    output logic [width_p-1:0] o_rd_dat,
    output logic               o_empty,
    output logic               o_full
);
    localparam int AW = (depth_p > 1) ? $clog2(depth_p) : 1;

    logic [AW-1:0]      r_wr_idx, r_rd_idx;
    logic               r_wr_wrap, r_rd_wrap;
    logic [width_p-1:0] r_mem [depth_p];
    logic               w_wr_en, w_rd_en;

    // Equal indices: the wrap bits tell empty (same lap) from full (one lap apart).
    assign o_empty  = (r_wr_idx == r_rd_idx) && (r_wr_wrap == r_rd_wrap);
    assign o_full   = (r_wr_idx == r_rd_idx) && (r_wr_wrap != r_rd_wrap);
    assign o_rd_dat = r_mem[r_rd_idx];

    // Full + read + write is fine: the head is consumed this cycle while the
    // new word lands in the slot being freed at the edge.
    assign w_wr_en = i_wr && (!o_full || i_rd);
    assign w_rd_en = i_rd && !o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_idx] <= i_wr_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_wr_wrap <= 1'b0;
            r_rd_wrap <= 1'b0;
        end else begin
            if (w_wr_en) begin
                if (r_wr_idx == AW'(depth_p - 1)) begin
                    r_wr_idx  <= '0;
                    r_wr_wrap <= ~r_wr_wrap;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            if (w_rd_en) begin
                if (r_rd_idx == AW'(depth_p - 1)) begin
                    r_rd_idx  <= '0;
                    r_rd_wrap <= ~r_rd_wrap;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/cfgtag_link_arbiter.sv
// Round-robin merge of num_in_p credit-based gateway streams onto one credit-based link.
// Latency: valid_i at t -> grant at t+1 -> valid_o/credit_o at t+2; 1 word/cycle peak.
// Backpressure: grants stop while the downstream credit count is zero; FIFOs hold their words.
//
// Ports: clk, reset (async active-low), link (cfgtag_link_arbiter_if.slave),
//        err_o (sticky error, only when CFGTAG_LINK_ARB_ERR_EN is defined).
module cfgtag_link_arbiter
    import cfgtag_link_arb_pkg::*;
#(
    parameter int num_in_p      = 4,
    parameter int data_width_p  = 32,
    parameter int in_credits_p  = 2,
    parameter int out_credits_p = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cfgtag_link_arbiter_if.slave  link
`ifdef CFGTAG_LINK_ARB_ERR_EN
    ,
    output logic                  err_o
`endif
);
    localparam int CW = credit_cnt_w(out_credits_p);
    localparam int IW = $clog2(num_in_p);

    logic [num_in_p-1:0]                   w_empty, w_full, w_wr, w_rd;
    logic [num_in_p-1:0][data_width_p-1:0] w_rd_dat;
    logic                                  w_gnt_vld;
    logic [IW-1:0]                         w_gnt_idx, w_cand;
    logic                                  w_credit_ok;

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_last;
    logic                    r_valid;
    logic [data_width_p-1:0] r_data;
    logic [IW-1:0]           r_gid;
    logic [num_in_p-1:0]     r_credit;

    assign w_wr = link.valid_i;

    for (genvar gi = 0; gi < num_in_p; gi++) begin : g_fifo
        cfgtag_link_arb_fifo #(
            .depth_p (in_credits_p),
            .width_p (data_width_p)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .i_wr     (w_wr[gi]),
            .i_wr_dat (link.data_i[gi]),
            .i_rd     (w_rd[gi]),
            .o_rd_dat (w_rd_dat[gi]),
            .o_empty  (w_empty[gi]),
            .o_full   (w_full[gi])
        );
    end

    // Search last+1, last+2, ... wrapping; first non-empty FIFO wins.
    // Only the registered credit count gates the grant.
    always_comb begin
        int cand;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_rd      = '0;
        cand      = 0;
        if (r_cnt != '0) begin
            for (int k = 1; k <= num_in_p; k++) begin
                cand = int'(r_last) + k;
                if (cand >= num_in_p) cand = cand - num_in_p;
                w_cand = IW'(cand);
                if (!w_gnt_vld && !w_empty[w_cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
        if (w_gnt_vld) w_rd[w_gnt_idx] = 1'b1;
    end

`ifdef CFGTAG_LINK_ARB_ERR_EN
    err_cause_e r_err_cause;
    logic       w_fifo_ovf, w_cred_ovf;

    // A credit beyond the initial count is dropped rather than counted.
    assign w_fifo_ovf  = |(w_wr & w_full & ~w_rd);
    assign w_cred_ovf  = link.credit_i && (r_cnt == CW'(out_credits_p));
    assign w_credit_ok = link.credit_i && !w_cred_ovf;
    assign err_o       = (r_err_cause != NONE);

    // Records the first cause; stays set until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_cause <= NONE;
        end else if (r_err_cause == NONE) begin
            if (w_fifo_ovf)      r_err_cause <= FIFO_OVF;
            else if (w_cred_ovf) r_err_cause <= CREDIT_OVF;
        end
    end
`else
    assign w_credit_ok = link.credit_i;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= CW'(out_credits_p);
            r_last   <= IW'(num_in_p - 1);
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_gid    <= '0;
            r_credit <= '0;
        end else begin
            r_cnt    <= r_cnt - CW'(w_gnt_vld) + CW'(w_credit_ok);
            r_valid  <= w_gnt_vld;
            r_credit <= w_rd;
            if (w_gnt_vld) begin
                r_last <= w_gnt_idx;
                r_data <= w_rd_dat[w_gnt_idx];
                r_gid  <= w_gnt_idx;
            end
        end
    end

    assign link.valid_o    = r_valid;
    assign link.data_o     = r_data;
    assign link.grant_id_o = r_gid;
    assign link.credit_o   = r_credit;
endmodule

// File: tb/tb_cfgtag_link_arbiter.sv
// Self-checking bench for cfgtag_link_arbiter (4 inputs, 32-bit, 2-deep FIFOs, 4 credits).
// Latency: n/a.
// Backpressure: n/a.
module tb_cfgtag_link_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cfgtag_link_arbiter_if #(.num_in_p(4), .data_width_p(32)) lif ();
`ifdef CFGTAG_LINK_ARB_ERR_EN
    logic err_o;
`endif

    cfgtag_link_arbiter #(
        .num_in_p(4), .data_width_p(32), .in_credits_p(2), .out_credits_p(4)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .link  (lif.slave)
`ifdef CFGTAG_LINK_ARB_ERR_EN
        ,
        .err_o (err_o)
`endif
    );

    typedef struct { logic [1:0] id; logic [31:0] dat; int cyc; logic [3:0] cred; } obs_t;
    typedef struct { logic [1:0] id; logic [31:0] dat; } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   cyc;
    bit   loop_en;
    int   cred_cnt[4];
    int   emit_cnt[4];
    int   errors = 0;
    int   checks = 0;

    // One clock: sample outputs at the falling edge, then move to just after the
    // next rising edge with pulse inputs cleared (credit looped back if enabled).
    task automatic tick();
        logic v;
        @(negedge clk);
        v = lif.valid_o;
        if (rst_n && v) begin
            obs_q.push_back('{lif.grant_id_o, lif.data_o, cyc, lif.credit_o});
            emit_cnt[lif.grant_id_o]++;
        end
        for (int i = 0; i < 4; i++) if (rst_n && lif.credit_o[i]) cred_cnt[i]++;
        @(posedge clk);
        #1;
        cyc++;
        lif.valid_i  = '0;
        lif.credit_i = loop_en & v;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        lif.valid_i  = '0;
        lif.data_i   = '0;
        lif.credit_i = 1'b0;
        loop_en      = 1'b0;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin cred_cnt[i] = 0; emit_cnt[i] = 0; end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic push_word(input int i, input logic [31:0] d);
        lif.valid_i[i] = 1'b1;
        lif.data_i[i]  = d;
        exp_q.push_back('{2'(i), d});
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (lif.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", lif.valid_o); end
        checks++; if (lif.data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h required 0", lif.data_o); end
        checks++; if (lif.grant_id_o !== 2'd0) begin errors++; $display("FAIL rst_gid: got %0d required 0", lif.grant_id_o); end
        checks++; if (lif.credit_o !== 4'b0) begin errors++; $display("FAIL rst_credit: got %b required 0000", lif.credit_o); end
        checks++; if (dut.r_cnt !== 3'd4) begin errors++; $display("FAIL rst_cnt: got %0d required 4", dut.r_cnt); end
        ticks(4);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rst_idle: got %0d words required 0", obs_q.size()); end
    endtask

    task automatic test_single_word();
        obs_t o;
        exp_t e;
        do_reset();
        loop_en = 1'b1;
        while (cyc < 5) tick();
        push_word(2, 32'hA5A5_0002);
        ticks(8);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d words required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (o.id !== e.id) begin errors++; $display("FAIL single_gid: got %0d required %0d", o.id, e.id); end
            checks++; if (o.dat !== e.dat) begin errors++; $display("FAIL single_data: got %h required %h", o.dat, e.dat); end
            checks++; if (o.cyc != 7) begin errors++; $display("FAIL single_latency: got cycle %0d required 7", o.cyc); end
            checks++; if (o.cred !== 4'b0100) begin errors++; $display("FAIL single_credit: got %b required 0100", o.cred); end
        end
        checks++; if (dut.r_cnt !== 3'd4) begin errors++; $display("FAIL single_cnt_restored: got %0d required 4", dut.r_cnt); end
    endtask

    task automatic test_fairness();
        obs_t o;
        exp_t e;
        int   first;
        do_reset();
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) push_word(i, 32'hF000_0000 | i);
        tick();
        for (int i = 0; i < 4; i++) push_word(i, 32'hF000_0010 | i);
        ticks(14);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL fair_count: got %0d words required 8", obs_q.size()); end
        first = (obs_q.size() != 0) ? obs_q[0].cyc : 0;
        for (int k = 0; obs_q.size() != 0 && exp_q.size() != 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.id !== e.id || o.dat !== e.dat)
                begin errors++; $display("FAIL fair_order[%0d]: got id=%0d dat=%h required id=%0d dat=%h", k, o.id, o.dat, e.id, e.dat); end
            checks++;
            if (o.cyc != first + k) begin errors++; $display("FAIL fair_rate[%0d]: got cycle %0d required %0d", k, o.cyc, first + k); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cred_cnt[i] != 2) begin errors++; $display("FAIL fair_credit_ret[%0d]: got %0d required 2", i, cred_cnt[i]); end
        end
    endtask

    task automatic test_credit_exhaustion();
        obs_t o;
        exp_t e;
        int   t;
        do_reset();
        for (int i = 0; i < 3; i++) push_word(i, 32'hC000_0000 | i);
        tick();
        for (int i = 0; i < 3; i++) push_word(i, 32'hC000_0010 | i);
        ticks(12);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL exh_count: got %0d words required 4", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() > 2) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.id !== e.id || o.dat !== e.dat)
                begin errors++; $display("FAIL exh_word: got id=%0d dat=%h required id=%0d dat=%h", o.id, o.dat, e.id, e.dat); end
        end
        obs_q.delete();
        for (int n = 0; n < 2; n++) begin
            t = cyc;
            lif.credit_i = 1'b1;
            ticks(6);
            checks++;
            if (obs_q.size() != 1 || exp_q.size() == 0) begin
                errors++; $display("FAIL exh_resume_count[%0d]: got %0d words required 1", n, obs_q.size());
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (o.id !== e.id || o.dat !== e.dat || o.cyc != t + 2)
                    begin errors++; $display("FAIL exh_resume[%0d]: got id=%0d dat=%h cyc=%0d required id=%0d dat=%h cyc=%0d", n, o.id, o.dat, o.cyc, e.id, e.dat, t + 2); end
            end
            obs_q.delete();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cred_cnt[i] != emit_cnt[i]) begin errors++; $display("FAIL exh_credit_ret[%0d]: got %0d required %0d", i, cred_cnt[i], emit_cnt[i]); end
        end
    endtask

    task automatic test_simultaneous_credit();
        obs_t o;
        exp_t e;
        int   d;
        do_reset();
        for (int i = 0; i < 3; i++) push_word(i, 32'h5000_0000 | i);
        ticks(8);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL sim_setup: got %0d words required 3", obs_q.size()); end
        obs_q.delete();
        exp_q.delete();
        d = cyc;
        push_word(3, 32'h5000_0013);
        push_word(0, 32'h5000_0010);
        tick();
        lif.credit_i = 1'b1;
        tick();
        checks++; if (dut.r_cnt !== 3'd1) begin errors++; $display("FAIL sim_cnt_hold: got %0d required 1", dut.r_cnt); end
        ticks(6);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL sim_count: got %0d words required 2", obs_q.size()); end
        for (int k = 0; obs_q.size() != 0 && exp_q.size() != 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.id !== e.id || o.dat !== e.dat || o.cyc != d + 2 + k)
                begin errors++; $display("FAIL sim_word[%0d]: got id=%0d dat=%h cyc=%0d required id=%0d dat=%h cyc=%0d", k, o.id, o.dat, o.cyc, e.id, e.dat, d + 2 + k); end
        end
        checks++; if (dut.r_cnt !== 3'd0) begin errors++; $display("FAIL sim_cnt_end: got %0d required 0", dut.r_cnt); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 4; i++) push_word(i, 32'hD000_0000 | i);
        ticks(2);
        checks++; if (lif.valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b required 1", lif.valid_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (lif.valid_o !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b required 0", lif.valid_o); end
        checks++; if (lif.credit_o !== 4'b0) begin errors++; $display("FAIL mid_async_credit: got %b required 0000", lif.credit_o); end
        checks++; if (dut.r_cnt !== 3'd4) begin errors++; $display("FAIL mid_cnt: got %0d required 4", dut.r_cnt); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
        ticks(10);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_after_release: got %0d words required 0", obs_q.size()); end
    endtask

`ifdef CFGTAG_LINK_ARB_ERR_EN
    task automatic test_err();
        obs_t o;
        exp_t e;
        do_reset();
        for (int i = 1; i < 4; i++) push_word(i, 32'hE000_0000 | i);
        tick();
        push_word(1, 32'hE000_0011);
        ticks(8);
        obs_q.delete();
        exp_q.delete();
        push_word(0, 32'hE000_0100);
        tick();
        push_word(0, 32'hE000_0101);
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_pre: got %b required 0", err_o); end
        lif.valid_i[0] = 1'b1;
        lif.data_i[0]  = 32'hE000_0102;
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", err_o); end
        ticks(3);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err_o); end
        for (int n = 0; n < 3; n++) begin lif.credit_i = 1'b1; tick(); end
        ticks(6);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL err_words: got %0d required 2", obs_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.id !== e.id || o.dat !== e.dat)
                begin errors++; $display("FAIL err_word: got id=%0d dat=%h required id=%0d dat=%h", o.id, o.dat, e.id, e.dat); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_fairness();
        test_credit_exhaustion();
        test_simultaneous_credit();
        test_reset_midstream();
`ifdef CFGTAG_LINK_ARB_ERR_EN
        test_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cfgtag_link_arbiter.md
# cfgtag_link_arbiter

Round-robin arbiter that lets up to `num_in_p` cfgtag gateways share one credit-flow-controlled raw-network output link. Each gateway's credit-based `valid/data` stream lands in a small per-input FIFO; the arbiter grants one word per cycle to a non-empty FIFO while downstream credits remain, and returns one credit to the gateway per dequeued word. It sits between the gateway instances of a multi-chain config-tag subsystem and the single raw-network injection port.

## Interface
- `num_in_p`, 4: number of gateway inputs, 2..8.
- `data_width_p`, 32: payload width.
- `in_credits_p`, 2: per-input FIFO depth. Equals the upstream gateway's initial credit count.
- `out_credits_p`, 4: initial downstream credit count. Equals the raw-network receive buffer depth.
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low. Assertion clears all state immediately; deassertion is synchronized externally.
- `valid_i`, input, `num_in_p`: per-gateway word valid. Credit-protected, so never refused.
- `data_i`, input, `num_in_p` x `data_width_p`: per-gateway word.
- `credit_o`, output, `num_in_p`: one-cycle pulse returning one credit to gateway i.
- `credit_i`, input, 1: one-cycle pulse, one downstream credit returned.
- `valid_o`, output, 1: registered word valid to the raw network.
- `data_o`, output, `data_width_p`: registered word.
- `grant_id_o`, output, `$clog2(num_in_p)`: source index of the current `valid_o` word.

## Operation
- **Per-input FIFO**
  - A word is written when `valid_i[i]` is high.
  - A word is read when the arbiter grants input i.
  - A simultaneous write and read on the same FIFO is legal, including when it is full.
- **Credit counter**
  - Width is `$clog2(out_credits_p+1)`; reset value is `out_credits_p`.
  - Next value = cnt − grant + `credit_i`. A grant together with `credit_i` leaves it unchanged.
- **Grant rule**
  - Computed combinationally in cycle t and only when cnt > 0 (registered value).
  - A `credit_i` arriving in cycle t is not usable until t+1.
  - Search order starts at `last_q+1` and wraps modulo `num_in_p`. The first non-empty FIFO wins and `last_q` updates to it.
  - Reset value of `last_q` is `num_in_p-1`, so input 0 has priority first.
- **Output register**
  - The granted word loads into `data_o`/`grant_id_o` with `valid_o`=1 at t+1.
  - With no grant, `valid_o`=0. `data_o` holds its previous value.
- **Upstream credit return**
  - `credit_o[i]` is a registered pulse in the cycle after the FIFO i dequeue.
- **Reset values**
  - `valid_o`=0, `data_o`=0, `grant_id_o`=0, `credit_o`=0.
  - All FIFOs are empty; cnt=`out_credits_p`.
- **Reset mid-operation**
  - In-flight FIFO words and outstanding credits are discarded.
  - Both gateways and the network must be reset in the same window.

## Timing
- Minimum latency: `valid_i` at cycle t gives FIFO not-empty at t+1, a grant at t+1, and `valid_o` at t+2.
- Throughput is 1 word/cycle, provided credits return at that rate (round-trip ≤ `out_credits_p` cycles).
- Fairness: any non-empty input is granted within `num_in_p` grant cycles.
- With cnt=0, `valid_o` stays 0 and the FIFOs retain their contents. No words are lost.

## Configuration
- `CFGTAG_LINK_ARB_ERR_EN`
  - **Defined:** adds an output `err_o` (1 bit) plus the sticky internal causes.
    - `err_o` is a sticky flag, set one cycle after either a write to a full FIFO with no same-cycle read, or `credit_i` while cnt==`out_credits_p`.
    - In both cases the offending event is dropped (no overwrite, no counter increment).
    - Cleared only by reset.
  - **Undefined:** the port is absent, no error logic is built, and these events are undefined behaviour.

## Structure
- **Package `cfgtag_link_arb_pkg`**
  - Credit-count width helper function.
  - `err_cause_e` enum: `NONE`, `FIFO_OVF`, `CREDIT_OVF`.
- **Sub-module `cfgtag_link_arb_fifo`**
  - Parameterized depth and width; two-pointer ring with a wrap bit for full/empty.
  - Instantiated `num_in_p` times in a generate loop.
- **Top level**
  - Round-robin search, credit counter, output registers and credit-return registers.

## Test plan
- **Single word:** after reset, `valid_i[2]`=1 with data 0xA5A5_0002 at cycle 5 → `valid_o`=1, `data_o`=0xA5A5_0002, `grant_id_o`=2 at cycle 7; `credit_o[2]` pulses at cycle 7.
- **Fairness:** all 4 inputs each send 2 words back-to-back, with `credit_i` looped back 1 cycle after each `valid_o` → output order by `grant_id_o` is 0,1,2,3,0,1,2,3.
- **Credit exhaustion:** `out_credits_p`=4, no `credit_i`, 6 words queued → exactly 4 `valid_o` pulses. One `credit_i` pulse at cycle T gives the 5th `valid_o` at T+2.
- **Simultaneous credit and grant:** cnt=1 with `credit_i` in the grant cycle → cnt stays 1 and the next word issues in the following cycle.
- **Reset mid-stream:** assert `reset` low for 1 cycle with 3 words queued → `valid_o` goes 0 asynchronously, cnt=4, and nothing is emitted after release without new `valid_i`.
- **With `CFGTAG_LINK_ARB_ERR_EN`:** a third `valid_i[0]` while FIFO 0 holds 2 words and cnt=0 → `err_o`=1 next cycle, stays 1, and only 2 words later emerge from input 0.
